// File: rtl/axis_pkg.sv
// Shared defaults and width helpers for the AXI-Stream word-unpacking path.
package axis_pkg;

  localparam int DEF_WORD_WIDTH = 16;
  localparam int DEF_BUS_WIDTH  = 64;

  function automatic int words_per_beat(input int bus, input int word);
    return bus / word;
  endfunction

endpackage

// File: rtl/axis_lowest_set.sv
// Lowest-set-bit finder: index of the lowest 1, any-bit-set, and at-most-one-bit-set flags.
module axis_lowest_set #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o,
  output logic          single_o
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

  assign any_o    = |vec_i;
  assign single_o = ((vec_i & (vec_i - N'(1))) == '0);

endmodule

// File: rtl/axis_unpack_words.sv
// Splits a wide keep-masked AXI-Stream beat into one word per output beat; 1-cycle latency.
// s_ready drops while more than one kept word remains; last word out and next beat in share a cycle.
module axis_unpack_words
  import axis_pkg::*;
#(
  parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int BUS_WIDTH      = DEF_BUS_WIDTH,
  parameter int WORDS_PER_BEAT = words_per_beat(BUS_WIDTH, WORD_WIDTH)
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  output logic                                 s_ready,
  input  logic                                 s_valid,
  input  logic                                 s_last,
  input  logic [WORDS_PER_BEAT*WORD_WIDTH-1:0] s_data,
  input  logic [WORDS_PER_BEAT-1:0]            s_keep,
  input  logic                                 m_ready,
  output logic                                 m_valid,
  output logic                                 m_last,
  output logic [WORD_WIDTH-1:0]                m_data,
  output logic                                 m_keep
);

  localparam int IW = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;
  localparam int DW = WORDS_PER_BEAT * WORD_WIDTH;

  logic [DW-1:0]             buf_data_q, buf_data_d;
  logic [WORDS_PER_BEAT-1:0] mask_q, mask_d;
  logic                      buf_last_q, buf_last_d;
  logic                      buf_valid_q, buf_valid_d;

  logic [IW-1:0] idx;
  logic          any;
  logic          single;
  logic          s_hs;
  logic          m_hs;

  axis_lowest_set #(
    .N  (WORDS_PER_BEAT),
    .IW (IW)
  ) u_lowest (
    .vec_i    (mask_q),
    .idx_o    (idx),
    .any_o    (any),
    .single_o (single)
  );

  assign s_ready = !buf_valid_q || (m_ready && single);
  assign s_hs    = s_valid && s_ready;
  assign m_hs    = buf_valid_q && m_ready;

  assign m_valid = buf_valid_q;
  assign m_keep  = any;
  assign m_last  = buf_last_q && single;

  always_comb begin
    m_data = '0;
    for (int i = 0; i < WORDS_PER_BEAT; i++) begin
      if (any && (idx == IW'(i))) m_data = buf_data_q[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  // A load in the same cycle as the final word-out overrides the drain.
  always_comb begin
    buf_data_d  = buf_data_q;
    mask_d      = mask_q;
    buf_last_d  = buf_last_q;
    buf_valid_d = buf_valid_q;
    if (m_hs) begin
      if (any) mask_d[idx] = 1'b0;
      if (single) buf_valid_d = 1'b0;
    end
    if (s_hs) begin
      buf_data_d  = s_data;
      mask_d      = s_keep;
      buf_last_d  = s_last;
      buf_valid_d = (|s_keep) || s_last;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      buf_data_q  <= '0;
      mask_q      <= '0;
      buf_last_q  <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      buf_data_q  <= buf_data_d;
      mask_q      <= mask_d;
      buf_last_q  <= buf_last_d;
      buf_valid_q <= buf_valid_d;
    end
  end

endmodule

// File: tb/tb_axis_unpack_words.sv
module tb_axis_unpack_words;

  localparam int BOUND = 5000;

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b1;
  logic        s_ready;
  logic        s_valid = 1'b0;
  logic        s_last  = 1'b0;
  logic [63:0] s_data  = '0;
  logic [3:0]  s_keep  = '0;
  logic        m_ready = 1'b1;
  logic        m_valid;
  logic        m_last;
  logic [15:0] m_data;
  logic        m_keep;

  int vectors     = 0;
  int miscompares = 0;
  bit rnd_en      = 1'b0;

  typedef struct {
    logic [15:0] d;
    logic        l;
    logic        k;
  } exp_t;
  exp_t exp_q[$];

  axis_unpack_words dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_ready (s_ready),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_data  (s_data),
    .s_keep  (s_keep),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_data  (m_data),
    .m_keep  (m_keep)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack4(input int w0, input int w1, input int w2, input int w3);
    return {w3[15:0], w2[15:0], w1[15:0], w0[15:0]};
  endfunction

  // Reference model: each accepted beat expands into its kept words in
  // ascending order; the final kept word of a last beat carries m_last, and
  // a last beat with nothing kept becomes one empty terminator.
  logic        hold;
  logic [15:0] hold_d;
  logic        hold_l, hold_k;
  always @(negedge aclk) begin
    if (!aresetn) begin
      hold = 1'b0;
    end else begin
      chk("m_valid_vs_model", m_valid, exp_q.size() != 0);
      if (m_valid && exp_q.size() != 0) begin
        chk("m_data", m_data, exp_q[0].d);
        chk("m_last", m_last, exp_q[0].l);
        chk("m_keep", m_keep, exp_q[0].k);
      end
      if (hold) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, hold_d);
        chk("stall_last", m_last, hold_l);
        chk("stall_keep", m_keep, hold_k);
      end
      hold   = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
      hold_k = m_keep;
      if (m_valid && m_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (s_valid && s_ready) begin
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
          if (s_keep[i]) begin
            exp_t e;
            e.d = s_data[i*16 +: 16];
            e.l = 1'b0;
            e.k = 1'b1;
            exp_q.push_back(e);
            n++;
          end
        end
        if (s_last) begin
          if (n > 0) begin
            exp_q[exp_q.size()-1].l = 1'b1;
          end else begin
            exp_t e;
            e.d = '0;
            e.l = 1'b1;
            e.k = 1'b0;
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (rnd_en && $urandom_range(999) < 20) m_ready = !m_ready;
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [3:0] k, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    @(negedge aclk);
    while (!s_ready && n < BOUND) begin
      @(negedge aclk);
      n++;
    end
    if (n >= BOUND) chk("s_ready_timeout", 0, 1);
    @(posedge aclk);
    #1;
    s_valid = 1'b0;
    s_keep  = '0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < BOUND) begin
      @(negedge aclk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #1 aresetn = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_keep", m_keep, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_s_ready", s_ready, 1);
    repeat (3) @(posedge aclk);
    #3 aresetn = 1'b1;

    // Full beat, four words streamed on consecutive cycles.
    @(posedge aclk); #1;
    s_valid = 1'b1; s_data = pack4(0, 1, 2, 3); s_keep = 4'b1111; s_last = 1'b1;
    #1;
    chk("t1_s_ready", s_ready, 1);
    chk("t1_pre_valid", m_valid, 0);
    @(posedge aclk); #1;
    s_valid = 1'b0;
    chk("t1_lat_valid", m_valid, 1);
    chk("t1_w0", m_data, 0);
    chk("t1_w0_last", m_last, 0);
    for (int i = 1; i < 4; i++) begin
      @(posedge aclk); #1;
      chk("t1_wn", m_data, i);
      chk("t1_wn_last", m_last, i == 3);
    end
    @(posedge aclk); #1;
    chk("t1_idle", m_valid, 0);

    // Sparse keep.
    s_valid = 1'b1; s_data = pack4(10, 20, 30, 40); s_keep = 4'b1010; s_last = 1'b1;
    @(posedge aclk); #1;
    s_valid = 1'b0;
    chk("t2_w1", m_data, 20);
    chk("t2_w1_last", m_last, 0);
    @(posedge aclk); #1;
    chk("t2_w3", m_data, 40);
    chk("t2_w3_last", m_last, 1);
    @(posedge aclk); #1;
    chk("t2_idle", m_valid, 0);

    // Empty non-last beat vanishes; empty last beat gives one terminator.
    s_valid = 1'b1; s_data = pack4(9, 9, 9, 9); s_keep = 4'b0000; s_last = 1'b0;
    @(posedge aclk); #1;
    chk("t3_drop", m_valid, 0);
    s_last = 1'b1;
    @(posedge aclk); #1;
    s_valid = 1'b0;
    chk("t3_valid", m_valid, 1);
    chk("t3_keep", m_keep, 0);
    chk("t3_last", m_last, 1);
    chk("t3_data", m_data, 0);
    @(posedge aclk); #1;
    chk("t3_idle", m_valid, 0);

    // Downstream stall holds the current word and blocks the input.
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = pack4(5, 6, 7, 8); s_keep = 4'b1111; s_last = 1'b1;
    @(posedge aclk); #1;
    s_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t5_data", m_data, 5);
      chk("t5_valid", m_valid, 1);
      chk("t5_s_ready", s_ready, 0);
      @(posedge aclk); #1;
    end
    m_ready = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    chk("t5_idle", m_valid, 0);

    // Reset mid-packet with two words still buffered.
    s_valid = 1'b1; s_data = pack4(10, 11, 12, 13); s_keep = 4'b1111; s_last = 1'b1;
    @(posedge aclk); #1;
    s_valid = 1'b0;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    chk("t6_pre", m_data, 12);
    m_ready = 1'b0;
    #1 aresetn = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_keep", m_keep, 0);
    chk("t6_rst_last", m_last, 0);
    chk("t6_rst_data", m_data, 0);
    repeat (3) @(posedge aclk);
    #3 aresetn = 1'b1;
    chk("t6_s_ready", s_ready, 1);
    m_ready = 1'b1;
    @(posedge aclk); #1;
    s_valid = 1'b1; s_data = pack4(100, 101, 102, 103); s_keep = 4'b1111; s_last = 1'b1;
    @(posedge aclk); #1;
    s_valid = 1'b0;
    chk("t6_restart_valid", m_valid, 1);
    chk("t6_restart_w0", m_data, 100);
    drain();

    // Long packet under random source/sink throttling.
    rnd_en = 1'b1;
    for (int b = 0; b < 202; b++) begin
      while ($urandom_range(999) < 5) begin
        @(posedge aclk); #1;
      end
      send_beat(pack4(4*b, 4*b+1, 4*b+2, 4*b+3), 4'b1111, b == 201);
    end
    rnd_en = 1'b0;
    m_ready = 1'b1;
    drain();
    @(posedge aclk); #1;
    chk("end_idle", m_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
